// File: rtl/io_read_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : io_read_port_buffer
//  Description : Per-port show-ahead receive FIFO feeding the I/O read stage.
//                Ready/valid input side, read_EF/read_rden output side.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_read_port_buffer #(
    parameter int WORD_WIDTH  = 36,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  in_data,
    input  logic                   read_rden,
    output logic                   read_EF,
    output logic [WORD_WIDTH-1:0]  read_data,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   underflow
);

    localparam int                     c_ptr_width = $clog2(DEPTH);
    localparam logic [c_ptr_width-1:0] c_last_ptr  = c_ptr_width'(DEPTH - 1);
    localparam logic [COUNT_WIDTH-1:0] c_depth     = COUNT_WIDTH'(DEPTH);
    localparam logic [COUNT_WIDTH-1:0] c_one       = COUNT_WIDTH'(1);

    logic [WORD_WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ptr_width-1:0] r_wr_ptr;
    logic [c_ptr_width-1:0] r_rd_ptr;
    logic [COUNT_WIDTH-1:0] r_count;
    logic                   r_underflow;

    logic w_not_empty;
    logic w_push;
    logic w_pop;

    assign w_not_empty = (r_count != '0);
    assign in_ready    = (r_count != c_depth);
    assign w_push      = in_valid & in_ready;
    assign w_pop       = read_rden & w_not_empty;

    assign read_EF   = w_not_empty;
    assign read_data = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign underflow = r_underflow;

    // Storage has no reset; read_data is masked while empty instead.
    always_ff @(posedge clock) begin
        if (reset_n && w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_one;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_one;
            end
            if (read_rden && !w_not_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_io_read_port_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_read_port_buffer
//  Description : Directed self-checking bench for io_read_port_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_read_port_buffer;

    localparam int WORD_WIDTH  = 36;
    localparam int DEPTH       = 4;
    localparam int COUNT_WIDTH = 5;

    logic                   clock;
    logic                   reset_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WORD_WIDTH-1:0]  in_data;
    logic                   read_rden;
    logic                   read_EF;
    logic [WORD_WIDTH-1:0]  read_data;
    logic [COUNT_WIDTH-1:0] count;
    logic                   underflow;

    int checks;
    int errors;

    io_read_port_buffer #(
        .WORD_WIDTH  (WORD_WIDTH),
        .DEPTH       (DEPTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .read_rden (read_rden),
        .read_EF   (read_EF),
        .read_data (read_data),
        .count     (count),
        .underflow (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        read_rden = 1'b1;
        in_data   = 36'h99;

        // Reset with traffic present
        cyc();
        cyc();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        read_rden = 1'b0;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ef", 64'(read_EF), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_uflow", 64'(underflow), 64'd0);
        chk("rst_data", 64'(read_data), 64'd0);

        // Fill
        in_valid = 1'b1;
        in_data  = 36'h1;
        cyc();
        chk("fill_ef", 64'(read_EF), 64'd1);
        chk("fill_head", 64'(read_data), 64'h1);
        chk("fill_cnt1", 64'(count), 64'd1);
        for (int i = 2; i <= 4; i++) begin
            in_data = 36'(i);
            cyc();
        end
        chk("full_cnt", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);

        // Held word while full is refused
        in_data = 36'h5;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("full_hold_cnt", 64'(count), 64'd4);
        end
        chk("full_hold_head", 64'(read_data), 64'h1);
        in_valid = 1'b0;

        // Pop two
        read_rden = 1'b1;
        cyc();
        chk("pop1_head", 64'(read_data), 64'h2);
        chk("pop1_cnt", 64'(count), 64'd3);
        cyc();
        chk("pop2_head", 64'(read_data), 64'h3);
        chk("pop2_cnt", 64'(count), 64'd2);
        read_rden = 1'b0;

        // Push 5,6 across the write-pointer wrap
        in_valid = 1'b1;
        in_data  = 36'h5;
        cyc();
        chk("wrap_cnt3", 64'(count), 64'd3);
        in_data = 36'h6;
        cyc();
        chk("wrap_cnt4", 64'(count), 64'd4);
        in_valid = 1'b0;

        // Drain four: 3,4,5,6
        read_rden = 1'b1;
        for (int i = 3; i <= 6; i++) begin
            chk("drain_head", 64'(read_data), 64'(i));
            cyc();
        end
        read_rden = 1'b0;
        chk("drain_cnt", 64'(count), 64'd0);
        chk("drain_ef", 64'(read_EF), 64'd0);
        chk("drain_data", 64'(read_data), 64'd0);

        // Simultaneous push/pop at count 2
        in_valid = 1'b1;
        in_data  = 36'h10;
        cyc();
        in_data = 36'h11;
        cyc();
        chk("sim_pre_cnt", 64'(count), 64'd2);
        read_rden = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 36'(8'h12 + i);
            chk("sim_head", 64'(read_data), 64'(8'h10 + i));
            cyc();
            chk("sim_cnt", 64'(count), 64'd2);
        end
        in_valid = 1'b0;
        chk("sim_tail0", 64'(read_data), 64'h16);
        cyc();
        chk("sim_tail1", 64'(read_data), 64'h17);
        cyc();
        read_rden = 1'b0;
        chk("sim_end_cnt", 64'(count), 64'd0);

        // Underflow
        read_rden = 1'b1;
        cyc();
        read_rden = 1'b0;
        chk("uf_cnt", 64'(count), 64'd0);
        chk("uf_flag", 64'(underflow), 64'd1);
        chk("uf_ef", 64'(read_EF), 64'd0);
        in_valid = 1'b1;
        in_data  = 36'h20;
        cyc();
        in_valid = 1'b0;
        chk("uf_push_head", 64'(read_data), 64'h20);
        chk("uf_push_cnt", 64'(count), 64'd1);
        read_rden = 1'b1;
        cyc();
        read_rden = 1'b0;
        chk("uf_pop_cnt", 64'(count), 64'd0);
        chk("uf_sticky", 64'(underflow), 64'd1);

        // Reset mid-operation with count 3
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 36'(8'h30 + i);
            cyc();
        end
        chk("mid_pre_cnt", 64'(count), 64'd3);
        reset_n   = 1'b0;
        in_data   = 36'h33;
        read_rden = 1'b1;
        cyc();
        reset_n   = 1'b1;
        in_valid  = 1'b0;
        read_rden = 1'b0;
        chk("mid_cnt", 64'(count), 64'd0);
        chk("mid_ef", 64'(read_EF), 64'd0);
        chk("mid_uflow", 64'(underflow), 64'd0);
        chk("mid_data", 64'(read_data), 64'd0);
        in_valid = 1'b1;
        in_data  = 36'hA;
        cyc();
        in_valid = 1'b0;
        chk("mid_push_head", 64'(read_data), 64'hA);
        chk("mid_push_cnt", 64'(count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
